// File: rtl/kid_motion_ctrl.sv
// Player motion controller: walk, multi-jump, gravity, save/respawn and a
// timed death state, one physics step per frame_clk edge.
module kid_motion_ctrl #(
    parameter int POS_W       = 10,
    parameter int VEL_W       = 6,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int H_SPEED     = 5,
    parameter int JUMP_V0     = 16,
    parameter int JUMP_V1     = 10,
    parameter int GRAVITY     = 2,
    parameter int V_TERM      = 12,
    parameter int MAX_JUMPS   = 2,
    parameter int X_MAX       = 607,
    parameter int Y_FLOOR     = 447,
    parameter int RUN_DIV     = 4,
    parameter int DEAD_FRAMES = 60
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic [POS_W-1:0]        spawn_x,
    input  logic [POS_W-1:0]        spawn_y,
    input  logic                    key_jump,
    input  logic                    key_left,
    input  logic                    key_right,
    input  logic                    key_save,
    input  logic                    key_respawn,
    input  logic                    ground,
    input  logic                    hit_floor,
    input  logic [POS_W-1:0]        snap_y,
    input  logic                    hit_top,
    input  logic [POS_W-1:0]        snap_top_y,
    input  logic                    collide,
    output logic [POS_W-1:0]        pos_x,
    output logic [POS_W-1:0]        pos_y,
    output logic signed [VEL_W-1:0] vel_y,
    output logic                    direction,
    output logic [2:0]              state,
    output logic                    anim_frame,
    output logic [2:0]              jumps_used
);
    localparam int XW    = POS_W + 2;
    localparam int CNT_W = $clog2(DEAD_FRAMES + 1);
    localparam int DIV_W = $clog2(RUN_DIV + 1);

    localparam logic signed [XW-1:0]    XMAX_S  = XW'(X_MAX);
    localparam logic signed [XW-1:0]    YFLR_S  = XW'(Y_FLOOR);
    localparam logic signed [VEL_W:0]   VTERM_S = (VEL_W+1)'(V_TERM);
    localparam logic signed [VEL_W-1:0] VJ0     = VEL_W'(-JUMP_V0);
    localparam logic signed [VEL_W-1:0] VJ1     = VEL_W'(-JUMP_V1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_JUMP = 3'd2,
        S_FALL = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    state_t                  st, st_nx;
    logic [POS_W-1:0]        px_nx, py_nx;
    logic [POS_W-1:0]        save_x, save_y, sx_nx, sy_nx;
    logic signed [VEL_W-1:0] vy_nx, v_grav;
    logic signed [VEL_W:0]   v_sum;
    logic                    dir_nx, anim_nx, hdir;
    logic                    jump_q, jump_edge;
    logic [2:0]              jmp_nx;
    logic [CNT_W-1:0]        dead_cnt, dcnt_nx;
    logic [DIV_W-1:0]        div_cnt, div_nx;
    logic signed [XW-1:0]    dx, x_sum, y_sum;
    logic [POS_W-1:0]        x_clamp, y_air;

    assign state     = st;
    assign jump_edge = key_jump & ~jump_q;

    always_comb begin
        dx   = '0;
        hdir = direction;
        if (key_left && !key_right) begin
            dx   = XW'(-H_SPEED);
            hdir = 1'b0;
        end else if (key_right && !key_left) begin
            dx   = XW'(H_SPEED);
            hdir = 1'b1;
        end
        x_sum = $signed({2'b00, pos_x}) + dx;
        if (x_sum[XW-1])         x_clamp = '0;
        else if (x_sum > XMAX_S) x_clamp = POS_W'(X_MAX);
        else                     x_clamp = x_sum[POS_W-1:0];

        y_sum = $signed({2'b00, pos_y}) + XW'(vel_y);
        if (y_sum[XW-1])         y_air = '0;
        else if (y_sum > YFLR_S) y_air = POS_W'(Y_FLOOR);
        else                     y_air = y_sum[POS_W-1:0];

        v_sum = (VEL_W+1)'(vel_y) + (VEL_W+1)'(GRAVITY);
        if (v_sum > VTERM_S) v_grav = VEL_W'(V_TERM);
        else                 v_grav = v_sum[VEL_W-1:0];
    end

    always_comb begin
        st_nx   = st;
        px_nx   = pos_x;
        py_nx   = pos_y;
        vy_nx   = vel_y;
        dir_nx  = direction;
        jmp_nx  = jumps_used;
        dcnt_nx = dead_cnt;
        sx_nx   = save_x;
        sy_nx   = save_y;
        if (st == S_DEAD) begin
            if (key_respawn || dead_cnt == '0) begin
                st_nx   = S_IDLE;
                px_nx   = save_x;
                py_nx   = save_y;
                vy_nx   = '0;
                jmp_nx  = '0;
                dcnt_nx = '0;
            end else begin
                dcnt_nx = dead_cnt - CNT_W'(1);
            end
        end else if (collide) begin
            st_nx   = S_DEAD;
            vy_nx   = '0;
            dcnt_nx = CNT_W'(DEAD_FRAMES - 1);
        end else if (key_respawn) begin
            st_nx  = S_IDLE;
            px_nx  = save_x;
            py_nx  = save_y;
            vy_nx  = '0;
            jmp_nx = '0;
        end else begin
            px_nx  = x_clamp;
            dir_nx = hdir;
            if (st == S_IDLE || st == S_RUN) begin
                if (key_save) begin
                    sx_nx = pos_x;
                    sy_nx = pos_y;
                end
                if (jump_edge) begin
                    vy_nx  = VJ0;
                    jmp_nx = 3'd1;
                    st_nx  = S_JUMP;
                end else if (!ground && pos_y < POS_W'(Y_FLOOR)) begin
                    // walking off a ledge spends the ground jump
                    vy_nx  = '0;
                    jmp_nx = 3'd1;
                    st_nx  = S_FALL;
                end else begin
                    st_nx = (dx != '0) ? S_RUN : S_IDLE;
                end
            end else if (st == S_JUMP && hit_top) begin
                py_nx = snap_top_y;
                vy_nx = '0;
                st_nx = S_FALL;
            end else if (st == S_FALL &&
                         (hit_floor || ground || y_air == POS_W'(Y_FLOOR))) begin
                py_nx  = hit_floor ? snap_y : (ground ? pos_y : y_air);
                vy_nx  = '0;
                jmp_nx = '0;
                st_nx  = S_IDLE;
            end else if (jump_edge && jumps_used < 3'(MAX_JUMPS)) begin
                vy_nx  = VJ1;
                jmp_nx = jumps_used + 3'd1;
                st_nx  = S_JUMP;
            end else begin
                vy_nx = v_grav;
                py_nx = y_air;
                if (st == S_JUMP && !v_grav[VEL_W-1]) st_nx = S_FALL;
            end
        end

        div_nx  = '0;
        anim_nx = 1'b0;
        if (st == S_RUN && st_nx == S_RUN) begin
            anim_nx = anim_frame;
            if (div_cnt == DIV_W'(RUN_DIV - 1)) begin
                anim_nx = ~anim_frame;
            end else begin
                div_nx = div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            st         <= S_IDLE;
            pos_x      <= spawn_x;
            pos_y      <= spawn_y;
            save_x     <= spawn_x;
            save_y     <= spawn_y;
            vel_y      <= '0;
            direction  <= 1'b1;
            anim_frame <= 1'b0;
            jumps_used <= '0;
            jump_q     <= 1'b0;
            dead_cnt   <= '0;
            div_cnt    <= '0;
        end else begin
            st         <= st_nx;
            pos_x      <= px_nx;
            pos_y      <= py_nx;
            save_x     <= sx_nx;
            save_y     <= sy_nx;
            vel_y      <= vy_nx;
            direction  <= dir_nx;
            anim_frame <= anim_nx;
            jumps_used <= jmp_nx;
            jump_q     <= key_jump;
            dead_cnt   <= dcnt_nx;
            div_cnt    <= div_nx;
        end
    end

endmodule

// File: tb/tb_kid_motion_ctrl.sv
// Directed bench for kid_motion_ctrl: vector table plus hand sequences
// for death timing, respawn, clamps, ceiling/floor and async reset.
module tb_kid_motion_ctrl;
    logic              frame_clk = 1'b0;
    logic              Reset_n;
    logic [9:0]        spawn_x, spawn_y, snap_y, snap_top_y;
    logic              key_jump, key_left, key_right, key_save, key_respawn;
    logic              ground, hit_floor, hit_top, collide;
    logic [9:0]        pos_x, pos_y;
    logic signed [5:0] vel_y;
    logic              direction, anim_frame;
    logic [2:0]        state, jumps_used;
    int                total = 0;
    int                bad = 0;

    localparam logic [6:0] K0 = 7'b0000000;
    localparam logic [6:0] KJ = 7'b1000000;
    localparam logic [6:0] KL = 7'b0100000;
    localparam logic [6:0] KR = 7'b0010000;
    localparam logic [6:0] KS = 7'b0001000;
    localparam logic [6:0] KP = 7'b0000100;
    localparam logic [6:0] KG = 7'b0000010;
    localparam logic [6:0] KH = 7'b0000001;
    localparam int SI = 0, SR = 1, SJ = 2, SF = 3, SD = 4;
    localparam int NV = 42;

    typedef struct {
        logic [6:0] k;
        int         sy;
        int         ex, ey, ev, est, edir, ean, ejmp;
    } vec_t;

    vec_t tbl[NV];

    always #5 frame_clk = ~frame_clk;

    kid_motion_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .key_jump   (key_jump),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_save   (key_save),
        .key_respawn(key_respawn),
        .ground     (ground),
        .hit_floor  (hit_floor),
        .snap_y     (snap_y),
        .hit_top    (hit_top),
        .snap_top_y (snap_top_y),
        .collide    (collide),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vel_y      (vel_y),
        .direction  (direction),
        .state      (state),
        .anim_frame (anim_frame),
        .jumps_used (jumps_used)
    );

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endfunction

    task automatic chk_all(string nm, int ex, int ey, int ev, int est,
                           int edir, int ean, int ejmp);
        chk({nm, ".x"},    int'(pos_x),      ex);
        chk({nm, ".y"},    int'(pos_y),      ey);
        chk({nm, ".vy"},   int'(vel_y),      ev);
        chk({nm, ".st"},   int'(state),      est);
        chk({nm, ".dir"},  int'(direction),  edir);
        chk({nm, ".anim"}, int'(anim_frame), ean);
        chk({nm, ".jmp"},  int'(jumps_used), ejmp);
    endtask

    task automatic drive(input logic [6:0] k, input int sy);
        {key_jump, key_left, key_right, key_save,
         key_respawn, ground, hit_floor} = k;
        snap_y     = 10'(sy);
        hit_top    = 1'b0;
        snap_top_y = '0;
        collide    = 1'b0;
    endtask

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{KR|KG, 0, 105, 200, 0, SR, 1, 0, 0};
        tbl[1]  = '{KR|KG, 0, 110, 200, 0, SR, 1, 0, 0};
        tbl[2]  = '{KR|KG, 0, 115, 200, 0, SR, 1, 0, 0};
        tbl[3]  = '{KR|KG, 0, 120, 200, 0, SR, 1, 0, 0};
        tbl[4]  = '{KR|KG, 0, 125, 200, 0, SR, 1, 1, 0};
        tbl[5]  = '{KR|KG, 0, 130, 200, 0, SR, 1, 1, 0};
        tbl[6]  = '{KR|KG, 0, 135, 200, 0, SR, 1, 1, 0};
        tbl[7]  = '{KR|KG, 0, 140, 200, 0, SR, 1, 1, 0};
        tbl[8]  = '{KL|KR|KG, 0, 140, 200, 0, SI, 1, 0, 0};
        tbl[9]  = '{KL|KG, 0, 135, 200, 0, SR, 0, 0, 0};
        tbl[10] = '{KL|KR|KG, 0, 135, 200, 0, SI, 0, 0, 0};
        tbl[11] = '{KG, 0, 135, 200, 0, SI, 0, 0, 0};
        tbl[12] = '{KJ|KG, 0, 135, 200, -16, SJ, 0, 0, 1};
        tbl[13] = '{KJ, 0, 135, 184, -14, SJ, 0, 0, 1};
        tbl[14] = '{KJ, 0, 135, 170, -12, SJ, 0, 0, 1};
        tbl[15] = '{KJ, 0, 135, 158, -10, SJ, 0, 0, 1};
        tbl[16] = '{KJ, 0, 135, 148, -8, SJ, 0, 0, 1};
        tbl[17] = '{KJ, 0, 135, 140, -6, SJ, 0, 0, 1};
        tbl[18] = '{KJ, 0, 135, 134, -4, SJ, 0, 0, 1};
        tbl[19] = '{KJ, 0, 135, 130, -2, SJ, 0, 0, 1};
        tbl[20] = '{KJ, 0, 135, 128, 0, SF, 0, 0, 1};
        tbl[21] = '{KJ, 0, 135, 128, 2, SF, 0, 0, 1};
        tbl[22] = '{K0, 0, 135, 130, 4, SF, 0, 0, 1};
        tbl[23] = '{KJ, 0, 135, 130, -10, SJ, 0, 0, 2};
        tbl[24] = '{K0, 0, 135, 120, -8, SJ, 0, 0, 2};
        tbl[25] = '{KJ, 0, 135, 112, -6, SJ, 0, 0, 2};
        tbl[26] = '{K0, 0, 135, 106, -4, SJ, 0, 0, 2};
        tbl[27] = '{K0, 0, 135, 102, -2, SJ, 0, 0, 2};
        tbl[28] = '{K0, 0, 135, 100, 0, SF, 0, 0, 2};
        tbl[29] = '{K0, 0, 135, 100, 2, SF, 0, 0, 2};
        tbl[30] = '{K0, 0, 135, 102, 4, SF, 0, 0, 2};
        tbl[31] = '{K0, 0, 135, 106, 6, SF, 0, 0, 2};
        tbl[32] = '{K0, 0, 135, 112, 8, SF, 0, 0, 2};
        tbl[33] = '{K0, 0, 135, 120, 10, SF, 0, 0, 2};
        tbl[34] = '{K0, 0, 135, 130, 12, SF, 0, 0, 2};
        tbl[35] = '{K0, 0, 135, 142, 12, SF, 0, 0, 2};
        tbl[36] = '{K0, 0, 135, 154, 12, SF, 0, 0, 2};
        tbl[37] = '{KH, 300, 135, 300, 0, SI, 0, 0, 0};
        tbl[38] = '{KR|KG, 0, 140, 300, 0, SR, 1, 0, 0};
        tbl[39] = '{KR|KG, 0, 145, 300, 0, SR, 1, 0, 0};
        tbl[40] = '{KR|KG, 0, 150, 300, 0, SR, 1, 0, 0};
        tbl[41] = '{KS|KG, 0, 150, 300, 0, SI, 1, 0, 0};

        Reset_n = 1'b0;
        spawn_x = 10'd100;
        spawn_y = 10'd200;
        drive(KG, 0);
        repeat (2) @(posedge frame_clk);
        #1;
        chk_all("rst", 100, 200, 0, SI, 1, 0, 0);
        Reset_n = 1'b1;
        tick;
        chk_all("rel", 100, 200, 0, SI, 1, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].k, tbl[i].sy);
            tick;
            chk_all($sformatf("v%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ev,
                    tbl[i].est, tbl[i].edir, tbl[i].ean, tbl[i].ejmp);
        end

        drive(KR|KG, 0);
        repeat (20) tick;
        chk_all("walk", 250, 300, 0, SR, 1, 0, 0);
        drive(KR|KG, 0);
        collide = 1'b1;
        tick;
        chk_all("die", 250, 300, 0, SD, 1, 0, 0);
        for (int i = 0; i < 59; i++) begin
            drive(i[0] ? (KJ|KR|KG) : (KL|KG), 0);
            collide = 1'b1;
            tick;
            chk($sformatf("dead%0d.st", i), int'(state), SD);
            chk($sformatf("dead%0d.x", i), int'(pos_x), 250);
        end
        drive(KG, 0);
        tick;
        chk_all("auto", 150, 300, 0, SI, 1, 0, 0);

        drive(KR|KG, 0);
        repeat (2) tick;
        drive(KG, 0);
        collide = 1'b1;
        tick;
        chk_all("die2", 160, 300, 0, SD, 1, 0, 0);
        drive(KG, 0);
        repeat (3) tick;
        chk("dead3.st", int'(state), SD);
        drive(KP|KG, 0);
        tick;
        chk_all("rsp_dead", 150, 300, 0, SI, 1, 0, 0);

        drive(KR|KG, 0);
        repeat (2) tick;
        drive(KP|KR|KG, 0);
        tick;
        chk_all("rsp_live", 150, 300, 0, SI, 1, 0, 0);

        drive(KJ|KG, 0);
        tick;
        drive(KS, 0);
        repeat (2) tick;
        chk_all("air_save", 150, 270, -12, SJ, 1, 0, 1);
        drive(KP, 0);
        tick;
        chk_all("save_ign", 150, 300, 0, SI, 1, 0, 0);

        Reset_n = 1'b0;
        spawn_x = 10'd3;
        spawn_y = 10'd440;
        drive(KG, 0);
        #1;
        chk_all("rst2", 3, 440, 0, SI, 1, 0, 0);
        Reset_n = 1'b1;
        drive(KL|KG, 0);
        tick;
        chk_all("clampL", 0, 440, 0, SR, 0, 0, 0);
        drive(K0, 0);
        tick;
        chk_all("walkoff", 0, 440, 0, SF, 0, 0, 1);
        tick;
        chk_all("fall1", 0, 440, 2, SF, 0, 0, 1);
        tick;
        chk_all("fall2", 0, 442, 4, SF, 0, 0, 1);
        tick;
        chk_all("fall3", 0, 446, 6, SF, 0, 0, 1);
        tick;
        chk_all("floor", 0, 447, 0, SI, 0, 0, 0);
        drive(KJ|KG, 0);
        tick;
        chk_all("jmp2", 0, 447, -16, SJ, 0, 0, 1);
        drive(K0, 0);
        tick;
        chk_all("up", 0, 431, -14, SJ, 0, 0, 1);
        drive(K0, 0);
        hit_top    = 1'b1;
        snap_top_y = 10'd420;
        tick;
        chk_all("ceil", 0, 420, 0, SF, 0, 0, 1);
        drive(KJ, 0);
        tick;
        chk_all("airj", 0, 420, -10, SJ, 0, 0, 2);
        drive(K0, 0);
        tick;
        chk_all("airj2", 0, 410, -8, SJ, 0, 0, 2);
        #3;
        Reset_n = 1'b0;
        #1;
        chk_all("rst_mid", 3, 440, 0, SI, 1, 0, 0);

        spawn_x = 10'd605;
        spawn_y = 10'd447;
        tick;
        Reset_n = 1'b1;
        drive(KR|KG, 0);
        tick;
        chk_all("clampR", 607, 447, 0, SR, 1, 0, 0);
        tick;
        chk_all("clampR2", 607, 447, 0, SR, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
